// File: rtl/mio_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// mio_bus_ctrl_if
//   Bundles the CPU-side request signals and the RAM/IO-side signals of the
//   memory/IO bus handshake stage.
//   master : CPU control path plus the RAM/peripheral environment
//            (drives requests, ram_dout, io_rdata, io_ack)
//   slave  : mio_bus_ctrl (drives rdata, mio_ready, bus_err, RAM and IO strobes)
//   Parameter RAM_AW must match the RAM_AW of the attached mio_bus_ctrl.
// -----------------------------------------------------------------------------
interface mio_bus_ctrl_if #(
  parameter int unsigned RAM_AW = 10
) ();
  logic              mem_r;
  logic              mem_w;
  logic              cpu_mio;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              mio_ready;
  logic              bus_err;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              io_req;
  logic              io_we;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ack;

  modport master (
    output mem_r, mem_w, cpu_mio, addr, wdata, ram_dout, io_rdata, io_ack,
    input  rdata, mio_ready, bus_err, ram_addr, ram_we, ram_din,
           io_req, io_we, io_addr, io_wdata
  );

  modport slave (
    input  mem_r, mem_w, cpu_mio, addr, wdata, ram_dout, io_rdata, io_ack,
    output rdata, mio_ready, bus_err, ram_addr, ram_we, ram_din,
           io_req, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mio_bus_ctrl
//   Memory/IO bus handshake stage between the multicycle CPU control FSM and
//   RAM/peripherals. A request (cpu_mio & (mem_r | mem_w)) accepted in IDLE is
//   decoded to RAM or IO space, the RAM wait states or the IO req/ack handshake
//   are sequenced, then mio_ready pulses for one cycle with rdata latched.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-low reset
//     bus    : mio_bus_ctrl_if.slave (CPU request, RAM and IO signals)
//   Parameters: RAM_AW (RAM word-address width), RAM_LAT (1..15 RAM cycles),
//     IO_NIB (addr[31:28] selecting IO space), TMO_CYC (IO ack timeout, 1..256).
//   Optional feature: define MIO_TIMEOUT_EN to abort an IO access after
//     TMO_CYC cycles without io_ack (bus_err set, reads return 32'hDEAD_BEEF).
// -----------------------------------------------------------------------------
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned RAM_LAT = 1,
  parameter logic [3:0]  IO_NIB  = 4'hF,
  parameter int unsigned TMO_CYC = 255
) (
  input logic           clk,
  input logic           reset,
  mio_bus_ctrl_if.slave bus
);
  if (RAM_LAT < 1 || RAM_LAT > 15 || TMO_CYC < 1 || TMO_CYC > 256) begin : g_param_check
    $error("mio_bus_ctrl: RAM_LAT must be 1..15 and TMO_CYC 1..256");
  end

  typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;          // 1 = write
  logic [31:0]       rdata_q, rdata_d;
  logic              mio_ready_q, mio_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              io_req_q, io_req_d;
  logic              io_we_q, io_we_d;
  logic [31:0]       io_addr_q, io_addr_d;
  logic [31:0]       io_wdata_q, io_wdata_d;
`ifdef MIO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0]        tmo_q, tmo_d;
`endif

  logic req;
  logic bad;

  assign req = bus.cpu_mio & (bus.mem_r | bus.mem_w);
  assign bad = (bus.mem_r & bus.mem_w) | (bus.addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    rdata_d     = rdata_q;
    mio_ready_d = 1'b0;
    bus_err_d   = bus_err_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;   // write strobe lives for the first RAM_WAIT cycle only
    ram_din_d   = ram_din_q;
    io_req_d    = io_req_q;
    io_we_d     = io_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
`ifdef MIO_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          dir_d = bus.mem_w;
          if (bad) begin
            bus_err_d   = 1'b1;
            mio_ready_d = 1'b1;
            state_d     = DONE;
          end else if (bus.addr[31:28] == IO_NIB) begin
            io_req_d   = 1'b1;
            io_we_d    = bus.mem_w;
            io_addr_d  = bus.addr;
            io_wdata_d = bus.wdata;
`ifdef MIO_TIMEOUT_EN
            tmo_d      = '0;
`endif
            state_d    = IO_WAIT;
          end else begin
            ram_addr_d = bus.addr[RAM_AW+1:2];
            ram_we_d   = bus.mem_w;
            ram_din_d  = bus.wdata;
            cnt_d      = CNT_INIT;
            state_d    = RAM_WAIT;
          end
        end
      end
      RAM_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!dir_q) rdata_d = bus.ram_dout;
          mio_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IO_WAIT: begin
        // ack is tested first so that an ack coinciding with expiry wins
        if (bus.io_ack) begin
          io_req_d    = 1'b0;
          io_we_d     = 1'b0;
          if (!dir_q) rdata_d = bus.io_rdata;
          mio_ready_d = 1'b1;
          state_d     = DONE;
        end
`ifdef MIO_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          io_req_d    = 1'b0;
          io_we_d     = 1'b0;
          bus_err_d   = 1'b1;
          if (!dir_q) rdata_d = 32'hDEAD_BEEF;
          mio_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      rdata_q     <= '0;
      mio_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
`ifdef MIO_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      rdata_q     <= rdata_d;
      mio_ready_q <= mio_ready_d;
      bus_err_q   <= bus_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      io_req_q    <= io_req_d;
      io_we_q     <= io_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
`ifdef MIO_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mio_ready = mio_ready_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.io_req    = io_req_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
endmodule

// File: tb/tb_mio_bus_ctrl.sv
`timescale 1ns/1ps
module tb_mio_bus_ctrl;
  localparam int unsigned RAM_AW  = 10;
  localparam int unsigned RAM_LAT = 2;
  localparam int unsigned TMO     = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mio_bus_ctrl_if #(.RAM_AW(RAM_AW)) bus ();

  mio_bus_ctrl #(
    .RAM_AW (RAM_AW),
    .RAM_LAT(RAM_LAT),
    .IO_NIB (4'hF),
    .TMO_CYC(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM environment: combinational read, write on ram_we
  logic [31:0] ram_arr [0:(1<<RAM_AW)-1];
  assign bus.ram_dout = ram_arr[bus.ram_addr];
  always @(posedge clk) if (reset && bus.ram_we) ram_arr[bus.ram_addr] <= bus.ram_din;

  // reference model state
  logic [31:0] ref_mem [0:(1<<RAM_AW)-1];
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;

  typedef struct { logic [31:0] rdata; bit err; int unsigned lat; int unsigned t0; } done_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int unsigned hi; } io_t;
  typedef struct { logic [RAM_AW-1:0] a; logic [31:0] d; } wr_t;
  done_t done_q[$];
  io_t   io_q[$];
  wr_t   wr_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // monitor: pops expectations whenever the DUT presents something
  initial begin
    done_t e;
    io_t   io;
    wr_t   wr;
    bit    io_active = 1'b0;
    int unsigned io_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        io_active = 1'b0;
      end else begin
        if (bus.mio_ready) begin
          if (done_q.size() == 0) flag("unexpected_mio_ready");
          else begin
            e = done_q.pop_front();
            check("rdata", bus.rdata, e.rdata);
            check("bus_err", 32'(bus.bus_err), 32'(e.err));
            check("latency", cyc - e.t0, e.lat);
          end
        end
        if (bus.ram_we) begin
          if (wr_q.size() == 0) flag("unexpected_ram_we");
          else begin
            wr = wr_q.pop_front();
            check("ram_wr_addr", 32'(bus.ram_addr), 32'(wr.a));
            check("ram_din", bus.ram_din, wr.d);
          end
        end
        if (bus.io_req) begin
          if (io_q.size() == 0) begin
            if (!io_active) flag("unexpected_io_req");
            io_active = 1'b1;
          end else begin
            io = io_q[0];
            check("io_we", 32'(bus.io_we), 32'(io.we));
            check("io_addr", bus.io_addr, io.addr);
            check("io_wdata", bus.io_wdata, io.wdata);
            io_cnt = io_active ? io_cnt + 1 : 1;
            io_active = 1'b1;
          end
        end else if (io_active) begin
          io_active = 1'b0;
          if (io_q.size() != 0) begin
            io = io_q.pop_front();
            check("io_req_cycles", io_cnt, io.hi);
          end
        end
      end
    end
  end

  // one transaction: model update, expectation push, drive, IO response, wait
  // d < 0 means the IO side never acks
  task automatic do_txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input bit hold, input logic [31:0] io_rd);
    done_t e;
    io_t   io;
    wr_t   wr;
    bit    is_err, is_io, got;
    logic [RAM_AW-1:0] word;
    is_err = (r && w) || (a[1:0] != 2'b00);
    is_io  = !is_err && (a[31:28] == 4'hF);
    word   = a[RAM_AW+1:2];
    if (is_err) begin
      m_err = 1'b1;
      e.lat = 1;
    end else if (is_io) begin
      if (d < 0) begin
        m_err = 1'b1;
        if (!w) m_rdata = 32'hDEAD_BEEF;
        e.lat = TMO + 1;
        io.hi = TMO;
      end else begin
        if (!w) m_rdata = io_rd;
        e.lat = d + 2;
        io.hi = d + 1;
      end
      io.we = w; io.addr = a; io.wdata = wd;
      io_q.push_back(io);
    end else begin
      if (w) begin
        ref_mem[word] = wd;
        wr.a = word; wr.d = wd;
        wr_q.push_back(wr);
      end else begin
        m_rdata = ref_mem[word];
      end
      e.lat = RAM_LAT + 1;
    end
    e.rdata = m_rdata;
    e.err   = m_err;
    e.t0    = cyc;
    done_q.push_back(e);
    bus.mem_r = r; bus.mem_w = w; bus.cpu_mio = 1'b1; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    if (!hold) begin
      bus.cpu_mio = 1'b0;
      bus.mem_r = 1'($urandom);
      bus.mem_w = 1'($urandom);
    end
    if (!is_err && !is_io) check("ram_addr", 32'(bus.ram_addr), 32'(word));
    if (is_io && d >= 0) begin
      repeat (d) @(negedge clk);
      bus.io_rdata = io_rd;
      bus.io_ack = 1'b1;
      @(negedge clk);
      bus.io_ack = 1'b0;
      bus.io_rdata = $urandom;
    end
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      if (bus.mio_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) flag("mio_ready_wait_expired");
    @(negedge clk);
    bus.cpu_mio = 1'b0;
  endtask

  task automatic idle_gap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.mem_r = 1'($urandom);
      bus.mem_w = 1'($urandom);
      bus.addr  = $urandom;
      bus.io_ack = ($urandom_range(0, 3) == 0);  // stray ack must be ignored
      @(negedge clk);
      bus.io_ack = 1'b0;
    end
  endtask

  task automatic rand_txn(input bit allow_err);
    logic [31:0] a, wd, io_rd;
    bit r, w, hold;
    int d;
    int unsigned kind;
    kind  = $urandom_range(0, allow_err ? 5 : 3);
    a     = $urandom;
    wd    = $urandom;
    io_rd = $urandom;
    hold  = 1'($urandom);
    d     = int'($urandom_range(0, 6));
    a[1:0] = 2'b00;
    case (kind)
      0, 1, 2: begin
        a[31:28] = 4'($urandom_range(0, 14));
        a[11:2]  = 10'($urandom_range(0, 15));
        r = (kind != 2); w = (kind == 2);
      end
      3: begin
        a[31:28] = 4'hF;
        w = 1'($urandom); r = !w;
      end
      4: begin
        r = 1'b1; w = 1'b1;
      end
      default: begin
        a[1:0] = 2'($urandom_range(1, 3));
        w = 1'($urandom); r = !w;
      end
    endcase
    do_txn(r, w, a, wd, d, hold, io_rd);
    idle_gap($urandom_range(0, 2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, bus.rdata, 32'h0);
    check({tag, "_mio_ready"}, 32'(bus.mio_ready), 32'h0);
    check({tag, "_bus_err"}, 32'(bus.bus_err), 32'h0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h0);
    check({tag, "_ram_we"}, 32'(bus.ram_we), 32'h0);
    check({tag, "_ram_din"}, bus.ram_din, 32'h0);
    check({tag, "_io_req"}, 32'(bus.io_req), 32'h0);
    check({tag, "_io_we"}, 32'(bus.io_we), 32'h0);
    check({tag, "_io_addr"}, bus.io_addr, 32'h0);
    check({tag, "_io_wdata"}, bus.io_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.cpu_mio = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.io_rdata = '0; bus.io_ack = 1'b0;
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      ref_mem[i] = $urandom;
      ram_arr[i] <= ref_mem[i];
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // directed: RAM read, RAM write, IO read
    ref_mem[4] = 32'h1234_5678;
    ram_arr[4] <= 32'h1234_5678;
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, 4, 1'b0, 32'h0000_CAFE);
    do_txn(1'b0, 1'b1, 32'hF000_0100, 32'h0BAD_F00D, 0, 1'b1, 32'h1111_1111);

    for (int i = 0; i < 30; i++) rand_txn(1'b0);

    // error paths
    do_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, 1'b1, 32'h0);

    // reset in the middle of a RAM read: immediate clear, no completion
    bus.mem_r = 1'b1; bus.mem_w = 1'b0; bus.cpu_mio = 1'b1; bus.addr = 32'h0000_0040;
    @(negedge clk);
    bus.cpu_mio = 1'b0; bus.mem_r = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    m_err = 1'b0;
    m_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("post_abort");

    for (int i = 0; i < 30; i++) rand_txn(1'b1);

`ifdef MIO_TIMEOUT_EN
    do_txn(1'b1, 1'b0, 32'hF000_0010, 32'h0, -1, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'hF000_0014, 32'h7777_0000, -1, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 32'hF000_0018, 32'h0, int'(TMO) - 1, 1'b0, 32'h5555_AAAA);
`endif

    repeat (4) @(negedge clk);
    check("done_q_drained", done_q.size(), 32'h0);
    check("io_q_drained", io_q.size(), 32'h0);
    check("wr_q_drained", wr_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
